param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 Parameter DATA_W, default 64, register width in bits.
REQ-002 Parameter NUM_REGS, default 32, register count; power of two, minimum 2; AW = log2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 2, read port count, range 1..4.
REQ-004 Parameter ZERO_REG, default NUM_REGS-1, index of the hardwired-zero register.
REQ-005 Clk  in  1  clock; one clock only, writes and state update on falling edge.
REQ-006 ResetL  in  1  asynchronous, active-low reset.
REQ-007 RAddr  in  NUM_RD*AW  packed read addresses; port i at bits [i*AW +: AW].
REQ-008 BusR  out  NUM_RD*DATA_W  packed read data; port i at bits [i*DATA_W +: DATA_W].
REQ-009 RW  in  AW  write address.
REQ-010 BusW  in  DATA_W  write data.
REQ-011 RegWr  in  1  write enable.
REQ-012 Clear  in  1  request to zero all registers.
REQ-013 Busy  out  1  clear sweep in progress.
REQ-014 Done  out  1  one-cycle pulse when the sweep completes.
REQ-015 DropCnt  out  8  saturating count of writes rejected while Busy.

Function
REQ-016 Reads are combinational: BusR port i equals the contents of register RAddr[i] with zero clock latency.
REQ-017 A read of ZERO_REG returns 0 at all times.
REQ-018 With RegWr=1, Busy=0 and RW!=ZERO_REG, BusW is written to register RW on the falling edge of Clk.
REQ-019 A write to ZERO_REG is discarded silently and is not counted in DropCnt.
REQ-020 Clear FSM states: IDLE and SWEEP.
REQ-021 In IDLE, Clear=1 sampled on a falling edge moves the FSM to SWEEP, loads the sweep counter with 0 and sets Busy=1.
REQ-022 In SWEEP, each falling edge writes 0 to the register at the counter value and increments the counter.
REQ-023 When a falling edge writes register NUM_REGS-1, the FSM returns to IDLE, Busy drops and Done=1 for exactly one cycle. A sweep takes NUM_REGS cycles.
REQ-024 Clear asserted during SWEEP is ignored; the sweep does not restart.
REQ-025 RegWr=1 during SWEEP (RW!=ZERO_REG) does not write, and DropCnt increments on that edge; DropCnt saturates at 255.
REQ-026 When Clear and RegWr are both sampled in IDLE on the same edge, the write completes on that edge and the sweep starts afterwards, so the written value is zeroed later by the sweep.
REQ-027 Reads during SWEEP return the current contents: already-swept registers read 0, unswept registers keep their old values.

Reset
REQ-028 ResetL=0 immediately clears all registers, sets FSM to IDLE and the counter to 0, and sets Busy=0, Done=0, DropCnt=0, independent of Clk.
REQ-029 Reset asserted mid-sweep aborts the sweep. After release, the block is IDLE with all registers 0.
REQ-030 Release of ResetL is synchronised by the system; the block needs no falling edge before the first legal write.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN: when defined, a read port whose address equals RW, while RegWr=1, Busy=0 and RW!=ZERO_REG, returns BusW combinationally. The stored value is unchanged until the edge.
REQ-032 Without REGFILE_BYPASS_EN, reads return the stored value only; new data becomes visible after the falling edge.

Structure
REQ-033 Shared package regfile_pkg holds the FSM state typedef (IDLE, SWEEP), default parameter constants and the DropCnt width constant.
REQ-034 The clear FSM, sweep counter, Done and DropCnt logic live in sub-module regfile_clear_fsm. The storage array and read muxes live in the top level.

Verification
REQ-035 Write sequence: after reset, write register k with value k for k = 0..30, then read with RAddr={1,0} -> BusR = {1,0}; read port 0 of register 31 -> 0.
REQ-036 Write 64'h12345678 to ZERO_REG (31) -> reads of register 31 return 0 and DropCnt stays 0.
REQ-037 Clear sweep: pulse Clear with all registers nonzero -> Busy=1 for 32 edges, Done pulses once, then every register reads 0.
REQ-038 Dropped writes: issue RegWr=1 to register 5 on 3 edges during SWEEP -> register 5 reads 0 after Done and DropCnt=3. Issue 300 dropped writes -> DropCnt=255.
REQ-039 Reset mid-sweep: drop ResetL at sweep edge 10 -> Busy=0, all registers 0, DropCnt=0 immediately.
REQ-040 Bypass: RAddr port 0 = RW = 13, BusW=64'hABCD, RegWr=1 before the edge -> with the macro, BusR port 0 = 64'hABCD before the edge; without the macro, BusR port 0 = old value until the edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for param_register_file: clear-FSM state type,
// default sizing constants and the DropCnt width.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_NUM_RD   = 2;
  localparam int unsigned DROP_W       = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/param_register_file_if.sv
// Bus bundle for param_register_file: read/write ports, clear request and
// clear-sweep status. The register file is the slave side.
interface param_register_file_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD
);

  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [NUM_RD*AW-1:0]     RAddr;
  logic [NUM_RD*DATA_W-1:0] BusR;
  logic [AW-1:0]            RW;
  logic [DATA_W-1:0]        BusW;
  logic                     RegWr;
  logic                     Clear;
  logic                     Busy;
  logic                     Done;
  logic [DROP_W-1:0]        DropCnt;

  modport master (
    output RAddr, RW, BusW, RegWr, Clear,
    input  BusR, Busy, Done, DropCnt
  );

  modport slave (
    input  RAddr, RW, BusW, RegWr, Clear,
    output BusR, Busy, Done, DropCnt
  );

endinterface

// File: rtl/regfile_clear_fsm.sv
// Clear-sweep controller for param_register_file. Walks every register index
// once (one per falling edge) while Busy, pulses Done after the last index,
// and counts writes that arrive during the sweep (saturating).
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ZERO_REG = NUM_REGS - 1
) (
  input  logic                        clk,
  input  logic                        reset_l,
  input  logic                        clear,
  input  logic                        reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] rw,
  output logic                        busy,
  output logic                        done,
  output logic [DROP_W-1:0]           drop_cnt,
  output logic [$clog2(NUM_REGS)-1:0] sweep_idx
);

  localparam int unsigned     AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0]   ZERO_IDX = AW'(ZERO_REG);

  clr_state_t    state;
  logic [AW-1:0] cnt;

  assign sweep_idx = cnt;

  // Sweep state, counter and all status outputs advance on the falling edge
  always_ff @(negedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            state <= SWEEP;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SWEEP: begin
          cnt <= cnt + AW'(1);
          // NUM_REGS is a power of two, so the last index is all ones
          if (cnt == '1) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          if (reg_wr && (rw != ZERO_IDX) && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/param_register_file.sv
// Parameterised multi-read, single-write register file with a hardwired-zero
// register and a clear sweep. Storage updates on the falling edge of Clk.
// Optional build macro REGFILE_BYPASS_EN: a read port addressing the register
// being written this cycle returns BusW combinationally.
module param_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = DEF_NUM_RD,
  parameter int unsigned ZERO_REG = NUM_REGS - 1
) (
  input logic                  Clk,
  input logic                  ResetL,
  param_register_file_if.slave bus
);

  localparam int unsigned   AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [NUM_RD*DATA_W-1:0] rd_bus;
  logic                     busy;
  logic                     done;
  logic [DROP_W-1:0]        drop_cnt;
  logic [AW-1:0]            sweep_idx;
  logic                     wr_ok;

  regfile_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_clear_fsm (
    .clk       (Clk),
    .reset_l   (ResetL),
    .clear     (bus.Clear),
    .reg_wr    (bus.RegWr),
    .rw        (bus.RW),
    .busy      (busy),
    .done      (done),
    .drop_cnt  (drop_cnt),
    .sweep_idx (sweep_idx)
  );

  assign wr_ok       = bus.RegWr && !busy && (bus.RW != ZERO_IDX);
  assign bus.Busy    = busy;
  assign bus.Done    = done;
  assign bus.DropCnt = drop_cnt;
  assign bus.BusR    = rd_bus;

  // Storage: sweep zeroing has priority; a write with Clear in IDLE lands
  // first because busy only rises after that edge
  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (busy) begin
      regs[sweep_idx] <= '0;
    end else if (wr_ok) begin
      regs[bus.RW] <= bus.BusW;
    end
  end

  // Combinational read muxes, zero register forced to 0
  always_comb begin
    rd_bus = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (bus.RAddr[i*AW +: AW] != ZERO_IDX) begin
        rd_bus[i*DATA_W +: DATA_W] = regs[bus.RAddr[i*AW +: AW]];
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.RAddr[i*AW +: AW] == bus.RW)) begin
        rd_bus[i*DATA_W +: DATA_W] = bus.BusW;
      end
`endif
    end
  end

endmodule

// File: tb/tb_param_register_file.sv
// Directed self-checking bench for param_register_file (32 x 64, 2 read ports).
module tb_param_register_file;
  import regfile_pkg::*;

  localparam int unsigned DW  = 64;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;

  logic        Clk = 1'b1;
  logic        ResetL;
  int unsigned total = 0;
  int unsigned bad   = 0;

  param_register_file_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) bus ();

  param_register_file #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD),
    .ZERO_REG (31)
  ) dut (
    .Clk    (Clk),
    .ResetL (ResetL),
    .bus    (bus.slave)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge Clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    bus.RAddr = {a1, a0};
    #1;
  endtask

  initial begin
    int unsigned n;
    int unsigned drops;
    int unsigned iter;
    bit          dropped;

    ResetL     = 1'b0;
    bus.RAddr  = '0;
    bus.RW     = '0;
    bus.BusW   = '0;
    bus.RegWr  = 1'b0;
    bus.Clear  = 1'b0;

    // Reset state
    #2;
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Done, 0);
    chk("rst_drop", bus.DropCnt, 0);
    rd(1, 0);
    chk("rst_read", bus.BusR, 0);
    #1 ResetL = 1'b1;

    // Write register k with value k, starting on the first edge after reset
    for (int k = 0; k <= 30; k++) begin
      bus.RW    = 5'(k);
      bus.BusW  = 64'(k);
      bus.RegWr = 1'b1;
      tick();
    end
    bus.RegWr = 1'b0;
    rd(1, 0);
    chk("rd_1_0", bus.BusR, {64'd1, 64'd0});
    rd(0, 31);
    chk("rd_zero_p0", bus.BusR[63:0], 0);
    rd(30, 17);
    chk("rd_30_17", bus.BusR, {64'd30, 64'd17});

    // Write to the zero register is discarded and not counted
    bus.RW = 5'd31; bus.BusW = 64'h12345678; bus.RegWr = 1'b1;
    tick();
    bus.RegWr = 1'b0;
    rd(31, 31);
    chk("zero_reg_rd", bus.BusR, 0);
    chk("zero_reg_drop", bus.DropCnt, 0);

    // Write-through visibility before the edge
    bus.RW = 5'd13; bus.BusW = 64'hABCD; bus.RegWr = 1'b1;
    rd(2, 13);
`ifdef REGFILE_BYPASS_EN
    chk("bypass_pre", bus.BusR, {64'd2, 64'hABCD});
`else
    chk("bypass_pre", bus.BusR, {64'd2, 64'd13});
`endif
    tick();
    bus.RegWr = 1'b0;
    rd(2, 13);
    chk("bypass_post", bus.BusR, {64'd2, 64'hABCD});

    // Make register 0 nonzero too
    bus.RW = 5'd0; bus.BusW = 64'hF0; bus.RegWr = 1'b1;
    tick();
    bus.RegWr = 1'b0;

    // Clear sweep with dropped writes and ignored Clear re-requests
    bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    chk("sweep_start_busy", bus.Busy, 1);
    chk("sweep_start_done", bus.Done, 0);
    for (int e = 1; e <= 32; e++) begin
      bus.RegWr = (e >= 3 && e <= 5);
      bus.RW    = 5'd5;
      bus.BusW  = 64'd55;
      bus.Clear = (e == 7 || e == 20);
      tick();
      bus.RegWr = 1'b0;
      bus.Clear = 1'b0;
      if (e < 32) begin
        chk($sformatf("sweep_busy_e%0d", e), bus.Busy, 1);
        chk($sformatf("sweep_done_e%0d", e), bus.Done, 0);
      end else begin
        chk("sweep_end_busy", bus.Busy, 0);
        chk("sweep_end_done", bus.Done, 1);
      end
      if (e == 10) begin
        rd(10, 9);
        chk("sweep_mid_rd", bus.BusR, {64'd10, 64'd0});
      end
    end
    tick();
    chk("post_sweep_done", bus.Done, 0);
    chk("post_sweep_busy", bus.Busy, 0);
    chk("post_sweep_drop", bus.DropCnt, 3);
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(i));
      chk($sformatf("cleared_r%0d", i), bus.BusR, 0);
    end

    // Write and Clear on the same idle edge: write lands, then gets swept
    bus.RW = 5'd7; bus.BusW = 64'd77; bus.RegWr = 1'b1; bus.Clear = 1'b1;
    tick();
    bus.RegWr = 1'b0; bus.Clear = 1'b0;
    rd(7, 7);
    chk("wr_clr_rd", bus.BusR, {64'd77, 64'd77});
    chk("wr_clr_busy", bus.Busy, 1);
    for (int e = 1; e <= 7; e++) tick();
    rd(7, 6);
    chk("wr_clr_e7", bus.BusR, {64'd77, 64'd0});
    tick();
    rd(7, 6);
    chk("wr_clr_e8", bus.BusR, 0);
    n = 0;
    while (bus.Busy && n < 40) begin tick(); n++; end
    chk("sweep2_end", bus.Busy, 0);

    // DropCnt saturation across repeated sweeps
    drops = 0;
    iter  = 0;
    while (drops < 300 && iter < 2000) begin
      dropped = 1'b0;
      bus.RW   = 5'd9;
      bus.BusW = 64'd1;
      if (bus.Busy) begin
        bus.RegWr = 1'b1; bus.Clear = 1'b0; drops++; dropped = 1'b1;
      end else begin
        bus.RegWr = 1'b0; bus.Clear = 1'b1;
      end
      tick();
      iter++;
      if (dropped && drops == 100) chk("drop_100", bus.DropCnt, 103);
      if (dropped && drops == 252) chk("drop_sat", bus.DropCnt, 255);
    end
    bus.RegWr = 1'b0; bus.Clear = 1'b0;
    chk("drop_loop", drops, 300);
    chk("drop_final", bus.DropCnt, 255);
    n = 0;
    while (bus.Busy && n < 40) begin tick(); n++; end
    chk("sweep3_end", bus.Busy, 0);

    // Reset in the middle of a sweep
    bus.RW = 5'd20; bus.BusW = 64'h2020; bus.RegWr = 1'b1;
    tick();
    bus.RegWr = 1'b0; bus.Clear = 1'b1;
    tick();
    bus.Clear = 1'b0;
    for (int e = 1; e <= 9; e++) tick();
    rd(20, 20);
    chk("pre_rst_r20", bus.BusR, {64'h2020, 64'h2020});
    ResetL = 1'b0;
    #1;
    chk("mid_rst_busy", bus.Busy, 0);
    chk("mid_rst_done", bus.Done, 0);
    chk("mid_rst_drop", bus.DropCnt, 0);
    rd(20, 5);
    chk("mid_rst_rd", bus.BusR, 0);
    ResetL = 1'b1;
    bus.RW = 5'd4; bus.BusW = 64'd44; bus.RegWr = 1'b1;
    tick();
    bus.RegWr = 1'b0;
    rd(20, 4);
    chk("post_rst_rd", bus.BusR, {64'd0, 64'd44});
    chk("post_rst_busy", bus.Busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
